mem_port_arbiter: RTL and testbench

//  Shares one unified instruction/data memory port between the fetch (IF) and memory (MEM) stages of
//  the pipelined MIPS core. Serialises requests and sequences each access with a req/ready handshake.

---
 rtl/mem_port_arbiter_if.sv | 46 ++++
 rtl/mem_port_arbiter.sv | 111 +++++++++++
 tb/tb_mem_port_arbiter.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the IF/MEM requesters, the arbiter and the unified memory port.
//   if_*      : fetch request/response (address, instruction, done pulse)
//   d_*       : MEM-stage request/response (we, address, store data, load data, done pulse)
//   mem_*     : single shared memory port (req/we/addr/wdata out, rdata/ready in)
//   err       : access timed out (pulses with a done)
//   stall_f/m : per-stage freeze requests to the hazard unit
// Modports: slave = arbiter side, master = requesters + memory model side.
interface mem_port_arbiter_if;
    localparam int unsigned W = 32;

    logic         if_req;
    logic [W-1:0] if_addr;
    logic [W-1:0] if_rdata;
    logic         if_done;

    logic         d_req;
    logic         d_we;
    logic [W-1:0] d_addr;
    logic [W-1:0] d_wdata;
    logic [W-1:0] d_rdata;
    logic         d_done;

    logic         err;

    logic         mem_req;
    logic         mem_we;
    logic [W-1:0] mem_addr;
    logic [W-1:0] mem_wdata;
    logic [W-1:0] mem_rdata;
    logic         mem_ready;

    logic         stall_f;
    logic         stall_m;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
        output if_rdata, if_done, d_rdata, d_done, err,
               mem_req, mem_we, mem_addr, mem_wdata, stall_f, stall_m
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
        input  if_rdata, if_done, d_rdata, d_done, err,
               mem_req, mem_we, mem_addr, mem_wdata, stall_f, stall_m
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one unified memory port between instruction fetch and the MEM stage.
// Data side wins by default; after MAX_D_STREAK consecutive D grants with a fetch
// waiting, the next grant goes to IF. Each access runs IDLE -> BUSY_x -> RESP -> IDLE,
// and an access with no mem_ready for TIMEOUT busy cycles completes with err and
// the poison word 32'hDEADBEEF.
// Ports: clk, reset_n (async, active-low), bus (mem_port_arbiter_if.slave).
module mem_port_arbiter #(
    parameter int unsigned MAX_D_STREAK = 4,
    parameter int unsigned TIMEOUT      = 64
) (
    input  logic               clk,
    input  logic               reset_n,
    mem_port_arbiter_if.slave  bus
);
    localparam int unsigned STREAK_W = $clog2(MAX_D_STREAK + 1);
    localparam int unsigned TIMER_W  = $clog2(TIMEOUT);
    localparam logic [31:0] ERR_DATA = 32'hDEADBEEF;

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} state_t;

    state_t              state;
    logic [STREAK_W-1:0] d_streak;
    logic [TIMER_W-1:0]  timer;
    logic                force_i;
    logic                grant_d;
    logic                grant_i;
    logic                timed_out;

    // Arbitration decision, only acted on in IDLE.
    always_comb begin
        force_i   = bus.if_req && (d_streak == STREAK_W'(MAX_D_STREAK));
        grant_d   = bus.d_req && !force_i;
        grant_i   = bus.if_req && !grant_d;
        timed_out = (timer == TIMER_W'(TIMEOUT - 1));
    end

    // Freeze requests go straight to the hazard unit.
    assign bus.stall_f = bus.if_req & ~bus.if_done;
    assign bus.stall_m = bus.d_req & ~bus.d_done;

    // Access sequencer with registered bus outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            d_streak      <= '0;
            timer         <= '0;
            bus.if_rdata  <= '0;
            bus.if_done   <= 1'b0;
            bus.d_rdata   <= '0;
            bus.d_done    <= 1'b0;
            bus.err       <= 1'b0;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
        end else begin
            bus.if_done <= 1'b0;
            bus.d_done  <= 1'b0;
            bus.err     <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        state         <= BUSY_D;
                        timer         <= '0;
                        bus.mem_req   <= 1'b1;
                        bus.mem_we    <= bus.d_we;
                        bus.mem_addr  <= bus.d_addr;
                        bus.mem_wdata <= bus.d_wdata;
                        // Streak only counts D grants that made a fetch wait.
                        if (!bus.if_req) begin
                            d_streak <= '0;
                        end else if (d_streak != STREAK_W'(MAX_D_STREAK)) begin
                            d_streak <= d_streak + STREAK_W'(1);
                        end
                    end else if (grant_i) begin
                        state         <= BUSY_I;
                        timer         <= '0;
                        d_streak      <= '0;
                        bus.mem_req   <= 1'b1;
                        bus.mem_we    <= 1'b0;
                        bus.mem_addr  <= bus.if_addr;
                        bus.mem_wdata <= '0;
                    end
                end
                BUSY_I, BUSY_D: begin
                    // mem_ready beats a coincident timeout.
                    if (bus.mem_ready || timed_out) begin
                        state       <= RESP;
                        bus.mem_req <= 1'b0;
                        bus.err     <= !bus.mem_ready;
                        if (state == BUSY_I) begin
                            bus.if_done  <= 1'b1;
                            bus.if_rdata <= bus.mem_ready ? bus.mem_rdata : ERR_DATA;
                        end else begin
                            bus.d_done  <= 1'b1;
                            bus.d_rdata <= bus.mem_ready ? bus.mem_rdata : ERR_DATA;
                        end
                    end else begin
                        timer <= timer + TIMER_W'(1);
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: transaction-level reference model compared
// every cycle, plus directed scenarios with literal expectations.
module tb_mem_port_arbiter;
    localparam int unsigned MAX_D  = 4;
    localparam int unsigned TMO    = 64;
    localparam logic [31:0] KEY    = 32'hA5A55A5A;
    localparam logic [31:0] POISON = 32'hDEADBEEF;

    logic clk;
    logic reset_n;
    mem_port_arbiter_if bus();

    mem_port_arbiter #(.MAX_D_STREAK(MAX_D), .TIMEOUT(TMO)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- requesters and memory model ----------------
    int          if_target = 0, if_served = 0;
    logic [31:0] if_base   = 32'h0;
    int          d_target  = 0, d_served = 0;
    logic [31:0] d_base    = 32'h0;
    logic [31:0] d_wbase   = 32'h0;
    logic        d_we_cfg  = 1'b0;
    int          lat       = 1;   // 0 = never ready, N = ready in Nth busy cycle

    // Fetch requester: holds if_req until done, then re-issues or drops.
    initial begin
        bus.if_req  = 1'b0;
        bus.if_addr = '0;
        forever begin
            @(negedge clk);
            if (bus.if_req && bus.if_done) begin
                if_served++;
                if (if_served < if_target) bus.if_addr = bus.if_addr + 32'd4;
                else bus.if_req = 1'b0;
            end else if (!bus.if_req && if_served < if_target) begin
                bus.if_req  = 1'b1;
                bus.if_addr = if_base;
            end
        end
    end

    // Data requester: back-to-back accesses at consecutive words.
    initial begin
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
        bus.d_addr  = '0;
        bus.d_wdata = '0;
        forever begin
            @(negedge clk);
            if (bus.d_req && bus.d_done) begin
                d_served++;
                if (d_served < d_target) begin
                    bus.d_addr  = bus.d_addr + 32'd4;
                    bus.d_wdata = bus.d_wdata + 32'd1;
                end else begin
                    bus.d_req = 1'b0;
                end
            end else if (!bus.d_req && d_served < d_target) begin
                bus.d_req   = 1'b1;
                bus.d_we    = d_we_cfg;
                bus.d_addr  = d_base;
                bus.d_wdata = d_wbase;
            end
        end
    end

    // Memory: data = addr ^ KEY; stray ready asserted whenever no request is open.
    initial begin
        int cnt;
        cnt           = 0;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (bus.mem_req) begin
                cnt++;
                bus.mem_ready = (lat != 0) && (cnt == lat);
            end else begin
                cnt           = 0;
                bus.mem_ready = 1'b1;
            end
            bus.mem_rdata = bus.mem_addr ^ KEY;
        end
    end

    // ---------------- reference model + per-cycle compare ----------------
    int          m_owner;   // 0 none, 1 fetch, 2 data
    int          m_busy;    // busy cycles elapsed for the open access
    int          m_run;     // D grants in a row that made a fetch wait
    bit          m_quiet;   // response cycle: no arbitration
    logic        e_mem_req, e_mem_we, e_if_done, e_d_done, e_err;
    logic [31:0] e_addr, e_wdata, e_if_rdata, e_d_rdata;

    logic [31:0] glog[$];
    logic        prev_req   = 1'b0;
    int          run_len    = 0;
    int          last_len   = 0;
    int          d_done_cnt = 0;
    int          err_cnt    = 0;
    logic        first_we   = 1'b0;
    logic [31:0] first_wd   = '0;
    logic [31:0] last_if_rd = '0;
    logic [31:0] last_d_rd  = '0;

    always @(posedge clk) begin
        logic [31:0] data;
        bit          d_wins;
        if (!reset_n) begin
            m_owner = 0; m_busy = 0; m_run = 0; m_quiet = 0;
            e_mem_req = 0; e_mem_we = 0; e_if_done = 0; e_d_done = 0; e_err = 0;
            e_addr = '0; e_wdata = '0; e_if_rdata = '0; e_d_rdata = '0;
        end else begin
            e_if_done = 0; e_d_done = 0; e_err = 0;
            if (m_quiet) begin
                m_quiet = 0;
            end else if (m_owner != 0) begin
                m_busy++;
                if (bus.mem_ready || m_busy == TMO) begin
                    data  = bus.mem_ready ? bus.mem_rdata : POISON;
                    e_err = !bus.mem_ready;
                    if (m_owner == 1) begin e_if_rdata = data; e_if_done = 1; end
                    else begin e_d_rdata = data; e_d_done = 1; end
                    m_owner = 0; e_mem_req = 0; m_quiet = 1;
                end
            end else begin
                d_wins = bus.d_req && !(bus.if_req && m_run >= MAX_D);
                if (d_wins) begin
                    m_owner = 2; m_busy = 0; e_mem_req = 1;
                    m_run   = bus.if_req ? m_run + 1 : 0;
                    e_addr  = bus.d_addr; e_mem_we = bus.d_we; e_wdata = bus.d_wdata;
                end else if (bus.if_req) begin
                    m_owner = 1; m_busy = 0; e_mem_req = 1; m_run = 0;
                    e_addr  = bus.if_addr; e_mem_we = 0;
                end
            end
        end
        #1;
        chk("mem_req",  32'(bus.mem_req),  32'(e_mem_req));
        chk("if_done",  32'(bus.if_done),  32'(e_if_done));
        chk("d_done",   32'(bus.d_done),   32'(e_d_done));
        chk("err",      32'(bus.err),      32'(e_err));
        chk("stall_f",  32'(bus.stall_f),  32'(bus.if_req & ~e_if_done));
        chk("stall_m",  32'(bus.stall_m),  32'(bus.d_req & ~e_d_done));
        chk("if_rdata", bus.if_rdata, e_if_rdata);
        chk("d_rdata",  bus.d_rdata,  e_d_rdata);
        if (e_mem_req) begin
            chk("mem_addr", bus.mem_addr, e_addr);
            chk("mem_we",   32'(bus.mem_we), 32'(e_mem_we));
            if (e_mem_we) chk("mem_wdata", bus.mem_wdata, e_wdata);
        end
        // Observations for the directed checks.
        if (bus.mem_req && !prev_req) begin
            glog.push_back(bus.mem_addr);
            first_we = bus.mem_we;
            first_wd = bus.mem_wdata;
        end
        if (bus.mem_req) run_len++;
        else if (run_len != 0) begin last_len = run_len; run_len = 0; end
        if (bus.d_done) begin d_done_cnt++; last_d_rd = bus.d_rdata; end
        if (bus.if_done) last_if_rd = bus.if_rdata;
        if (bus.err) err_cnt++;
        prev_req = bus.mem_req;
    end

    // Wait until both requesters are satisfied and the port is quiet.
    task automatic wait_quiet(input int budget, input string name);
        int k;
        for (k = 0; k < budget; k++) begin
            @(posedge clk); #2;
            if (if_served == if_target && d_served == d_target &&
                !bus.mem_req && !bus.if_done && !bus.d_done) break;
        end
        if (k == budget) begin
            n_tests++; n_fail++;
            $display("FAIL %s: timed out after %0d cycles", name, budget);
        end
        repeat (2) @(posedge clk);
        #2;
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        int d0, e0;
        reset_n   = 1'b0;
        lat       = 1;
        if_base   = 32'h0;
        if_target = 1;

        // 1: reset with if_req held, then minimum-latency fetch.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mem_req",  32'(bus.mem_req), 32'h0);
        chk("rst_if_done",  32'(bus.if_done), 32'h0);
        chk("rst_d_done",   32'(bus.d_done),  32'h0);
        chk("rst_err",      32'(bus.err),     32'h0);
        chk("rst_if_rdata", bus.if_rdata,     32'h0);
        chk("rst_d_rdata",  bus.d_rdata,      32'h0);
        chk("rst_mem_addr", bus.mem_addr,     32'h0);
        chk("rst_mem_we",   32'(bus.mem_we),  32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("t1_req_c1",  32'(bus.mem_req), 32'h1);
        chk("t1_addr_c1", bus.mem_addr,     32'h0);
        @(posedge clk); #1;
        chk("t1_done_c2", 32'(bus.if_done), 32'h1);
        chk("t1_rdata",   bus.if_rdata,     32'hA5A55A5A);
        wait_quiet(50, "t1_wait");

        // 2: simultaneous requests, data first.
        glog.delete();
        if_base = 32'h200; d_base = 32'h80;
        if_target = if_served + 1; d_target = d_served + 1;
        wait_quiet(50, "t2_wait");
        chk("t2_grants", 32'(glog.size()), 32'd2);
        if (glog.size() == 2) begin
            chk("t2_first",  glog[0], 32'h80);
            chk("t2_second", glog[1], 32'h200);
        end

        // 3: starvation guard: four D grants, one I grant, D resumes.
        glog.delete();
        lat = 2;
        if_base = 32'h300; d_base = 32'h100;
        if_target = if_served + 1; d_target = d_served + 6;
        wait_quiet(200, "t3_wait");
        begin
            logic [31:0] exp3 [7];
            exp3 = '{32'h100, 32'h104, 32'h108, 32'h10C, 32'h300, 32'h110, 32'h114};
            chk("t3_grants", 32'(glog.size()), 32'd7);
            if (glog.size() == 7)
                for (int i = 0; i < 7; i++) chk($sformatf("t3_grant%0d", i), glog[i], exp3[i]);
        end

        // 4: store.
        glog.delete();
        lat = 3; d_we_cfg = 1'b1; d_base = 32'h40; d_wbase = 32'h12345678;
        d0 = d_done_cnt;
        d_target = d_served + 1;
        wait_quiet(50, "t4_wait");
        chk("t4_addr",  (glog.size() > 0) ? glog[0] : 32'hFFFFFFFF, 32'h40);
        chk("t4_we",    32'(first_we), 32'h1);
        chk("t4_wdata", first_wd, 32'h12345678);
        chk("t4_dones", 32'(d_done_cnt - d0), 32'd1);
        d_we_cfg = 1'b0;

        // 5: timeout, then ready on the last allowed cycle.
        lat = 0; if_base = 32'h500; e0 = err_cnt;
        if_target = if_served + 1;
        wait_quiet(150, "t5a_wait");
        chk("t5a_busy_len", 32'(last_len), 32'd64);
        chk("t5a_err",      32'(err_cnt - e0), 32'd1);
        chk("t5a_rdata",    last_if_rd, POISON);
        lat = 64; if_base = 32'h504; e0 = err_cnt;
        if_target = if_served + 1;
        wait_quiet(150, "t5b_wait");
        chk("t5b_busy_len", 32'(last_len), 32'd64);
        chk("t5b_err",      32'(err_cnt - e0), 32'd0);
        chk("t5b_rdata",    last_if_rd, 32'hA5A55F5E);

        // 6: reset in the middle of a data access.
        glog.delete();
        lat = 0; d_base = 32'h600; e0 = err_cnt;
        d_target = d_served + 1;
        repeat (5) @(posedge clk);
        #3;
        chk("t6_busy", 32'(bus.mem_req), 32'h1);
        reset_n = 1'b0;
        #1;
        chk("t6_async_drop", 32'(bus.mem_req), 32'h0);
        repeat (2) @(negedge clk);
        lat = 2;
        reset_n = 1'b1;
        wait_quiet(50, "t6_wait");
        chk("t6_regrant", (glog.size() > 0) ? glog[glog.size()-1] : 32'hFFFFFFFF, 32'h600);
        chk("t6_rdata",   last_d_rd, 32'hA5A55C5A);
        chk("t6_no_err",  32'(err_cnt - e0), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
